// File: rtl/frame_pp_pkg.sv
// Shared types and constants for the frame ping-pong buffer.
// The drop counter width applies only when FRAME_PP_DROP_CNT_EN is defined.
package frame_pp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int DROP_CNT_WIDTH = 16;

endpackage

// File: rtl/dpram_1clk.sv
// Single-clock simple dual-port RAM with a registered read address.
// A read of a word written on the same edge returns the new data.
module dpram_1clk #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] raddr_reg;

  // Contents are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_reg <= '0;
    end else begin
      raddr_reg <= raddr;
    end
  end

  assign rdata = mem[raddr_reg];

endmodule

// File: rtl/frame_pingpong_buf.sv
// Two-bank frame buffer: the writer fills one bank while the reader consumes the other.
// Defining FRAME_PP_DROP_CNT_EN adds a saturating drop_cnt output.
module frame_pingpong_buf
  import frame_pp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int OVERWRITE  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_frame_end,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_release,
  output logic                  rd_bank
`ifdef FRAME_PP_DROP_CNT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);

  state_t state_reg, state_next;
  logic   wbank_reg, wbank_next;
  logic   rbank_reg, rbank_next;
  logic   mem_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wbank_reg <= 1'b0;
      rbank_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wbank_reg <= wbank_next;
      rbank_reg <= rbank_next;
    end
  end

  // A "swap" hands the just-completed writer bank to the reader.
  always_comb begin
    state_next = state_reg;
    wbank_next = wbank_reg;
    rbank_next = rbank_reg;
    case (state_reg)
      IDLE: begin
        if (wr_frame_end) begin
          state_next = READY;
          rbank_next = wbank_reg;
          wbank_next = ~wbank_reg;
        end
      end
      READY: begin
        if (wr_frame_end && rd_release) begin
          rbank_next = wbank_reg;
          wbank_next = ~wbank_reg;
        end else if (wr_frame_end) begin
          state_next = FULL;
        end else if (rd_release) begin
          state_next = IDLE;
        end
      end
      FULL: begin
        if (rd_release) begin
          state_next = READY;
          rbank_next = wbank_reg;
          wbank_next = ~wbank_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_ready = (state_reg != FULL) || (OVERWRITE != 0);
  assign rd_valid = (state_reg != IDLE);
  assign rd_bank  = rbank_reg;
  assign mem_we   = wr_en && wr_ready;

  dpram_1clk #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH + 1)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr ({wbank_reg, wr_addr}),
    .wdata (wr_data),
    .raddr ({rbank_reg, rd_addr}),
    .rdata (rd_data)
  );

`ifdef FRAME_PP_DROP_CNT_EN
  // Any frame end seen while FULL is lost, even when a release arrives with it.
  logic frame_drop;
  assign frame_drop = (state_reg == FULL) && wr_frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (frame_drop && (drop_cnt != {DROP_CNT_WIDTH{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule
